// File: rtl/coke_controller.sv
`timescale 1ns/1ps
// coke_controller: sequencing controller for the coke-machine interface.
// Tracks customer credit in nickels, runs the dispense / bill-mover /
// change-maker 4-phase handshakes and drives the lights and price.
module coke_controller #(
    parameter int unsigned BILL_VALUE  = 20,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] price,
    input  logic [5:0] empty,
    input  logic [5:0] press,
    input  logic       insq,
    input  logic       insd,
    input  logic       insn,
    input  logic [2:0] numq,
    input  logic [2:0] numd,
    input  logic [2:0] numn,
    input  logic       billsns,
    input  logic       billok,
    input  logic       billng,
    input  logic       cnret,
    input  logic       billack,
    input  logic       dispack,
    input  logic       chgack,
    output logic [7:0] cost,
    output logic [5:0] disp,
    output logic [5:0] elight,
    output logic       insack,
    output logic       chgcom,
    output logic       retins,
    output logic       chgq,
    output logic       chgd,
    output logic       chgn,
    output logic       billin,
    output logic       billout,
    output logic       nochg,
    output logic       billlt,
    output logic [7:0] credit
);

    localparam int unsigned CW = 8;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_COIN_ACK,
        S_BILL_IN,
        S_BILL_WAIT,
        S_BILL_OUT,
        S_VEND_REQ,
        S_VEND_REL,
        S_COMMIT,
        S_RET,
        S_CHG_SEL,
        S_CHG_REQ,
        S_CHG_REL
    } state_t;

    state_t        state, state_n;
    logic          rel, rel_n;          // handshake phase: 1 = waiting for ACK to fall
    logic          billed, billed_n;
    logic [CW-1:0] credit_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [5:0]    disp_n;
    logic          insack_n, chgcom_n, retins_n;
    logic          chgq_n, chgd_n, chgn_n, billin_n, billout_n;

    logic [5:0]    sel;
    logic          sel_hit;
    logic [CW-1:0] coin_val;
    logic [CW-1:0] pay;
    logic [SW-1:0] coin_sum;
    logic [SW-1:0] bill_sum;
    logic          waiting;
    logic          progress;

    // Lowest pressed button whose slot still has product.
    always_comb begin
        sel     = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!sel_hit && press[i] && !empty[i]) begin
                sel[i]  = 1'b1;
                sel_hit = 1'b1;
            end
        end
    end

    // Credit arithmetic helpers: coin value (Q > D > N), paid change coin, sums.
    always_comb begin
        coin_val = insq ? CW'(5) : insd ? CW'(2) : insn ? CW'(1) : CW'(0);
        pay      = chgq ? CW'(5) : chgd ? CW'(2) : CW'(1);
        coin_sum = SW'(credit) + SW'(coin_val);
        bill_sum = SW'(credit) + SW'(BILL_VALUE);
        waiting  = state inside {S_BILL_IN, S_BILL_WAIT, S_BILL_OUT, S_VEND_REQ,
                                 S_VEND_REL, S_COMMIT, S_RET, S_CHG_REQ, S_CHG_REL};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        rel_n     = rel;
        credit_n  = credit;
        billed_n  = billed;
        disp_n    = disp;
        insack_n  = insack;
        chgcom_n  = chgcom;
        retins_n  = retins;
        chgq_n    = chgq;
        chgd_n    = chgd;
        chgn_n    = chgn;
        billin_n  = billin;
        billout_n = billout;
        progress  = 1'b0;
        tmo_n     = '0;

        unique case (state)
            S_IDLE: begin
                rel_n = 1'b0;
                if (cnret && credit != '0) begin
                    if (billed) begin
                        chgcom_n = 1'b1;
                        state_n  = S_COMMIT;
                    end else begin
                        retins_n = 1'b1;
                        state_n  = S_RET;
                    end
                end else if (sel_hit && credit >= cost) begin
                    disp_n  = sel;
                    state_n = S_VEND_REQ;
                end else if (billsns && billlt) begin
                    billin_n = 1'b1;
                    state_n  = S_BILL_IN;
                end else if (insq || insd || insn) begin
                    state_n = S_COIN_ACK;
                end
            end

            S_COIN_ACK: begin
                if (!insack) begin
                    if (coin_val != '0) begin
                        credit_n = (coin_sum > SW'(255)) ? CW'(255) : coin_sum[CW-1:0];
                        insack_n = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (!(insq || insd || insn)) begin
                    insack_n = 1'b0;
                    state_n  = S_IDLE;
                end
            end

            S_BILL_IN: begin
                if (!rel) begin
                    if (billack) begin
                        billin_n = 1'b0;
                        rel_n    = 1'b1;
                    end
                end else if (!billack) begin
                    rel_n   = 1'b0;
                    state_n = S_BILL_WAIT;
                end
            end

            S_BILL_WAIT: begin
                if (billok && bill_sum <= SW'(255)) begin
                    credit_n = bill_sum[CW-1:0];
                    billed_n = 1'b1;
                    state_n  = S_IDLE;
                end else if (billok || billng) begin
                    billout_n = 1'b1;
                    state_n   = S_BILL_OUT;
                end
            end

            S_BILL_OUT: begin
                if (!rel) begin
                    if (billack) begin
                        billout_n = 1'b0;
                        rel_n     = 1'b1;
                    end
                end else if (!billack) begin
                    rel_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end

            S_VEND_REQ: begin
                if (dispack) begin
                    disp_n  = '0;
                    state_n = S_VEND_REL;
                end
            end

            S_VEND_REL: begin
                if (!dispack) begin
                    if (credit >= cost) begin
                        credit_n = credit - cost;
                    end
                    billed_n = 1'b0;
                    chgcom_n = 1'b1;
                    state_n  = S_COMMIT;
                end
            end

            S_COMMIT: begin
                if (!rel) begin
                    if (chgack) begin
                        chgcom_n = 1'b0;
                        rel_n    = 1'b1;
                    end
                end else if (!chgack) begin
                    rel_n   = 1'b0;
                    state_n = S_CHG_SEL;
                end
            end

            S_RET: begin
                if (!rel) begin
                    if (chgack) begin
                        retins_n = 1'b0;
                        rel_n    = 1'b1;
                    end
                end else if (!chgack) begin
                    rel_n    = 1'b0;
                    credit_n = '0;
                    state_n  = S_IDLE;
                end
            end

            S_CHG_SEL: begin
                if (credit >= CW'(5) && numq != '0) begin
                    chgq_n  = 1'b1;
                    state_n = S_CHG_REQ;
                end else if (credit >= CW'(2) && numd != '0) begin
                    chgd_n  = 1'b1;
                    state_n = S_CHG_REQ;
                end else if (credit >= CW'(1) && numn != '0) begin
                    chgn_n  = 1'b1;
                    state_n = S_CHG_REQ;
                end else begin
                    // Unpayable residue is forfeited.
                    credit_n = '0;
                    billed_n = 1'b0;
                    state_n  = S_IDLE;
                end
            end

            S_CHG_REQ: begin
                if (chgack) begin
                    if (credit >= pay) begin
                        credit_n = credit - pay;
                    end
                    chgq_n  = 1'b0;
                    chgd_n  = 1'b0;
                    chgn_n  = 1'b0;
                    state_n = S_CHG_REL;
                end
            end

            S_CHG_REL: begin
                if (!chgack) begin
                    state_n = S_CHG_SEL;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        progress = (state_n != state) || (rel_n != rel);

        // Abort a stalled handshake; credit is kept.
        if (waiting && !progress && tmo == TW'(ACK_TIMEOUT - 1)) begin
            disp_n    = '0;
            chgcom_n  = 1'b0;
            retins_n  = 1'b0;
            chgq_n    = 1'b0;
            chgd_n    = 1'b0;
            chgn_n    = 1'b0;
            billin_n  = 1'b0;
            billout_n = 1'b0;
            rel_n     = 1'b0;
            state_n   = S_IDLE;
        end

        if (waiting && state_n == state && rel_n == rel) begin
            tmo_n = tmo + TW'(1);
        end
    end

    // State, credit and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rel     <= 1'b0;
            tmo     <= '0;
            credit  <= '0;
            billed  <= 1'b0;
            cost    <= '0;
            disp    <= '0;
            elight  <= '0;
            insack  <= 1'b0;
            chgcom  <= 1'b0;
            retins  <= 1'b0;
            chgq    <= 1'b0;
            chgd    <= 1'b0;
            chgn    <= 1'b0;
            billin  <= 1'b0;
            billout <= 1'b0;
            nochg   <= 1'b0;
            billlt  <= 1'b0;
        end else begin
            state   <= state_n;
            rel     <= rel_n;
            tmo     <= tmo_n;
            credit  <= credit_n;
            billed  <= billed_n;
            cost    <= (state == S_IDLE) ? price : cost;
            disp    <= disp_n;
            elight  <= empty;
            insack  <= insack_n;
            chgcom  <= chgcom_n;
            retins  <= retins_n;
            chgq    <= chgq_n;
            chgd    <= chgd_n;
            chgn    <= chgn_n;
            billin  <= billin_n;
            billout <= billout_n;
            nochg   <= (numn == '0);
            billlt  <= (numn != '0) && (state == S_IDLE);
        end
    end

endmodule

// File: tb/tb_coke_controller.sv
`timescale 1ns/1ps
// tb_coke_controller: table vectors, directed corner sequences and random
// transactions checked against a credit/change arithmetic model.
module tb_coke_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] price = 8'd0;
    logic [5:0] empty = 6'd0, press = 6'd0;
    logic       insq = 1'b0, insd = 1'b0, insn = 1'b0;
    logic [2:0] numq = 3'd0, numd = 3'd0, numn = 3'd0;
    logic       billsns = 1'b0, billok = 1'b0, billng = 1'b0, cnret = 1'b0;
    logic       billack = 1'b0, dispack = 1'b0, chgack = 1'b0;
    logic [7:0] cost, credit;
    logic [5:0] disp, elight;
    logic       insack, chgcom, retins, chgq, chgd, chgn, billin, billout, nochg, billlt;

    coke_controller #(.BILL_VALUE(20), .ACK_TIMEOUT(1023)) dut (
        .clk(clk), .rst_n(rst_n), .price(price), .empty(empty), .press(press),
        .insq(insq), .insd(insd), .insn(insn), .numq(numq), .numd(numd), .numn(numn),
        .billsns(billsns), .billok(billok), .billng(billng), .cnret(cnret),
        .billack(billack), .dispack(dispack), .chgack(chgack),
        .cost(cost), .disp(disp), .elight(elight), .insack(insack), .chgcom(chgcom),
        .retins(retins), .chgq(chgq), .chgd(chgd), .chgn(chgn), .billin(billin),
        .billout(billout), .nochg(nochg), .billlt(billlt), .credit(credit)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit en_disp = 1'b1, en_chg = 1'b1, en_bill = 1'b1;
    int cnt_q = 0, cnt_d = 0, cnt_n = 0, cnt_ret = 0, cnt_com = 0;
    int cnt_disp = 0, cnt_bin = 0, cnt_bout = 0, cnt_ins = 0, viol = 0;
    logic [5:0] last_disp = 6'd0;
    logic p_q = 0, p_d = 0, p_n = 0, p_ret = 0, p_com = 0, p_disp = 0, p_bin = 0, p_bout = 0, p_ins = 0;

    // Model state and expected per-operation deltas.
    int m_credit = 0;
    bit m_billed = 0;
    int e_q, e_d, e_n, e_ret, e_com, e_disp, e_bin, e_bout, e_ins;
    int s_q, s_d, s_n, s_ret, s_com, s_disp, s_bin, s_bout, s_ins;
    logic [5:0] exp_disp;

    // Peripheral responders: ACK follows the request half a cycle later.
    always @(negedge clk) begin
        dispack = en_disp && (|disp);
        chgack  = en_chg && (chgcom || retins || chgq || chgd || chgn);
        billack = en_bill && (billin || billout);
    end

    // Rising-edge counters and single-request monitor.
    always @(negedge clk) begin
        if (chgq && !p_q) cnt_q++;
        if (chgd && !p_d) cnt_d++;
        if (chgn && !p_n) cnt_n++;
        if (retins && !p_ret) cnt_ret++;
        if (chgcom && !p_com) cnt_com++;
        if ((|disp) && !p_disp) begin cnt_disp++; last_disp = disp; end
        if (billin && !p_bin) cnt_bin++;
        if (billout && !p_bout) cnt_bout++;
        if (insack && !p_ins) cnt_ins++;
        if ($countones({disp, chgcom, retins, chgq, chgd, chgn, billin, billout}) > 1) viol++;
        p_q = chgq; p_d = chgd; p_n = chgn; p_ret = retins; p_com = chgcom;
        p_disp = |disp; p_bin = billin; p_bout = billout; p_ins = insack;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        int n = 0;
        while (q < 8 && n < 4000) begin
            @(negedge clk);
            n++;
            if (!((|disp) || chgcom || retins || chgq || chgd || chgn || billin || billout || insack)) q++;
            else q = 0;
        end
        if (q < 8) begin
            n_tests++; n_fail++;
            $display("FAIL %s idle: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic snap();
        s_q = cnt_q; s_d = cnt_d; s_n = cnt_n; s_ret = cnt_ret; s_com = cnt_com;
        s_disp = cnt_disp; s_bin = cnt_bin; s_bout = cnt_bout; s_ins = cnt_ins;
        e_q = 0; e_d = 0; e_n = 0; e_ret = 0; e_com = 0; e_disp = 0; e_bin = 0; e_bout = 0; e_ins = 0;
    endtask

    task automatic verify(input string tag);
        check({tag, " credit"}, credit, m_credit);
        check({tag, " chgq"}, cnt_q - s_q, e_q);
        check({tag, " chgd"}, cnt_d - s_d, e_d);
        check({tag, " chgn"}, cnt_n - s_n, e_n);
        check({tag, " retins"}, cnt_ret - s_ret, e_ret);
        check({tag, " chgcom"}, cnt_com - s_com, e_com);
        check({tag, " disp"}, cnt_disp - s_disp, e_disp);
        check({tag, " billin"}, cnt_bin - s_bin, e_bin);
        check({tag, " billout"}, cnt_bout - s_bout, e_bout);
        check({tag, " insack"}, cnt_ins - s_ins, e_ins);
        if (e_disp != 0) check({tag, " disp_sel"}, last_disp, exp_disp);
    endtask

    // Greedy change as plain division: quarters, then dimes, then nickels.
    task automatic model_change();
        int r = m_credit;
        int q, d, n;
        q = (numq != 0) ? r / 5 : 0; r -= 5 * q;
        d = (numd != 0) ? r / 2 : 0; r -= 2 * d;
        n = (numn != 0) ? r : 0;
        e_q += q; e_d += d; e_n += n;
        m_credit = 0; m_billed = 0;
    endtask

    task automatic set_env(input int q, input int d, input int n, input logic [5:0] e, input int p);
        numq = 3'(q); numd = 3'(d); numn = 3'(n); empty = e; price = 8'(p);
        repeat (3) @(negedge clk);
    endtask

    task automatic op_coin(input int kind, input string tag);
        int n = 0;
        int v = (kind == 0) ? 5 : (kind == 1) ? 2 : 1;
        snap();
        @(negedge clk);
        insq = (kind == 0); insd = (kind == 1); insn = (kind == 2);
        while (!insack && n < 20) begin @(negedge clk); n++; end
        check({tag, " insack_seen"}, insack, 1);
        insq = 0; insd = 0; insn = 0;
        m_credit = (m_credit + v > 255) ? 255 : m_credit + v;
        e_ins = 1;
        wait_quiet(tag);
        verify(tag);
    endtask

    task automatic op_press(input logic [5:0] bits, input string tag);
        int idx = -1;
        snap();
        for (int i = 5; i >= 0; i--) if (bits[i] && !empty[i]) idx = i;
        if (idx >= 0 && m_credit >= price) begin
            e_disp = 1;
            exp_disp = 6'd1 << idx;
            m_credit -= price;
            m_billed = 0;
            e_com = 1;
            model_change();
        end
        @(negedge clk); press = bits;
        @(negedge clk); press = 6'd0;
        wait_quiet(tag);
        verify(tag);
    endtask

    task automatic op_cnret(input string tag);
        snap();
        if (m_credit != 0) begin
            if (!m_billed) begin e_ret = 1; m_credit = 0; end
            else begin e_com = 1; model_change(); end
        end
        @(negedge clk); cnret = 1'b1;
        @(negedge clk); cnret = 1'b0;
        wait_quiet(tag);
        verify(tag);
    endtask

    task automatic op_bill(input bit ok, input string tag);
        int n = 0;
        snap();
        @(negedge clk); billsns = 1'b1;
        if (numn == 0) begin
            repeat (6) @(negedge clk);
            billsns = 1'b0;
        end else begin
            while (!billin && n < 10) begin @(negedge clk); n++; end
            billsns = 1'b0;
            n = 0;
            while (billin && n < 20) begin @(negedge clk); n++; end
            billok = ok; billng = !ok;
            repeat (6) @(negedge clk);
            billok = 1'b0; billng = 1'b0;
            e_bin = 1;
            if (ok && m_credit + 20 <= 255) begin m_credit += 20; m_billed = 1; end
            else e_bout = 1;
        end
        wait_quiet(tag);
        verify(tag);
    endtask

    typedef struct {
        logic [5:0] empty;
        logic [2:0] numn;
        logic [5:0] exp_elight;
        logic       exp_nochg;
        logic       exp_billlt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{6'b000000, 3'd0, 6'b000000, 1'b1, 1'b0};
        vecs[1] = '{6'b000001, 3'd1, 6'b000001, 1'b0, 1'b1};
        vecs[2] = '{6'b101010, 3'd7, 6'b101010, 1'b0, 1'b1};
        vecs[3] = '{6'b111111, 3'd0, 6'b111111, 1'b1, 1'b0};
        vecs[4] = '{6'b010101, 3'd3, 6'b010101, 1'b0, 1'b1};
        vecs[5] = '{6'b100000, 3'd2, 6'b100000, 1'b0, 1'b1};

        // Reset state.
        price = 8'd14;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {cost, disp, elight, insack, chgcom, retins, chgq, chgd,
                                chgn, billin, billout, nochg, billlt, credit}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Light/indicator vectors in IDLE.
        for (int i = 0; i < 6; i++) begin
            empty = vecs[i].empty; numn = vecs[i].numn;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d elight", i), elight, vecs[i].exp_elight);
            check($sformatf("vec%0d nochg", i), nochg, vecs[i].exp_nochg);
            check($sformatf("vec%0d billlt", i), billlt, vecs[i].exp_billlt);
        end
        check("cost follows price in idle", cost, 14);

        // Coins, vend, change of 3 as dime + nickel.
        set_env(0, 3, 3, 6'b000000, 14);
        op_coin(0, "t1 q1"); check("t1 credit5", credit, 5);
        op_coin(0, "t1 q2"); check("t1 credit10", credit, 10);
        op_coin(1, "t1 d");  check("t1 credit12", credit, 12);
        op_coin(0, "t1 q3"); check("t1 credit17", credit, 17);
        op_press(6'b000100, "t1 vend");
        check("t1 disp onehot", last_disp, 6'b000100);

        // Coin return of unbilled credit.
        repeat (4) op_coin(2, "t3 n");
        op_cnret("t3 ret");

        // Bill accepted, then change of 20 as four quarters.
        set_env(3, 3, 2, 6'b000000, 14);
        op_bill(1'b1, "t2 bill");
        check("t2 credit20", credit, 20);
        op_cnret("t2 cnret");
        check("t2 four quarters", cnt_q - s_q, 4);

        // Rejected bill, then bill that would overflow 255.
        op_coin(1, "t4 d");
        op_bill(1'b0, "t4 billng");
        op_cnret("t4 clear");
        for (int i = 0; i < 48; i++) op_coin(0, "t4 q");
        check("t4 credit240", credit, 240);
        op_bill(1'b1, "t4 overflow");
        op_cnret("t4 clear2");

        // Ignored presses, then a stalled dispense.
        set_env(2, 2, 2, 6'b000001, 10);
        op_coin(0, "t5 q");
        op_press(6'b000010, "t5 short");
        op_coin(0, "t5 q2");
        op_press(6'b000001, "t5 emptyslot");
        en_disp = 1'b0;
        snap();
        @(negedge clk); press = 6'b000010;
        @(negedge clk); press = 6'b000000;
        n = 0;
        while (disp != 6'b000010 && n < 10) begin @(negedge clk); n++; end
        check("t5 disp raised", disp, 6'b000010);
        n = 0;
        while ((|disp) && n < 1100) begin n++; @(negedge clk); end
        n_tests++;
        if (n < 1021 || n > 1025) begin
            n_fail++;
            $display("FAIL t5 timeout_len: disp held %0d cycles, expected about 1023", n);
        end
        en_disp = 1'b1;
        e_disp = 1; exp_disp = 6'b000010;
        wait_quiet("t5 timeout");
        verify("t5 timeout");
        op_coin(2, "t5 after");
        op_cnret("t5 clear");

        // Randomised transactions.
        for (int it = 0; it < 80; it++) begin
            int sel;
            if (it % 6 == 0)
                set_env($urandom_range(3), $urandom_range(3), $urandom_range(3),
                        6'($urandom_range(63)), $urandom_range(40, 1));
            sel = $urandom_range(99);
            if (sel < 45) op_coin($urandom_range(2), $sformatf("r%0d coin", it));
            else if (sel < 60) op_bill(1'($urandom_range(1)), $sformatf("r%0d bill", it));
            else if (sel < 85) begin
                logic [5:0] b;
                b = (sel < 80) ? 6'(1 << $urandom_range(5)) : 6'($urandom_range(63));
                op_press(b, $sformatf("r%0d press", it));
            end else op_cnret($sformatf("r%0d cnret", it));
        end

        // Reset in the middle of change-making.
        set_env(3, 3, 2, 6'b000000, 14);
        op_cnret("t6 pre");
        op_bill(1'b1, "t6 bill");
        @(negedge clk); cnret = 1'b1;
        @(negedge clk); cnret = 1'b0;
        n = 0;
        while (!chgq && n < 60) begin @(negedge clk); n++; end
        check("t6 reached chgq", chgq, 1);
        rst_n = 1'b0;
        #1;
        check("t6 outputs cleared", {cost, disp, elight, insack, chgcom, retins, chgq, chgd,
                                     chgn, billin, billout, nochg, billlt}, 0);
        check("t6 credit cleared", credit, 0);
        m_credit = 0; m_billed = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        op_coin(2, "t6 coin");

        check("single request at a time", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
